// File: rtl/ctrl_pkg.sv
// Shared control definitions: FSM state codes, opcode constants, opcode classes, ALU op codes.
package ctrl_pkg;

   typedef enum logic [2:0] {
      StIdle   = 3'd0,
      StFetch  = 3'd1,
      StDecode = 3'd2,
      StExec   = 3'd3,
      StMem    = 3'd4,
      StWb     = 3'd5,
      StHalt   = 3'd6
   } state_e;

   typedef enum logic [2:0] {
      ClsR      = 3'd0,
      ClsIAlu   = 3'd1,
      ClsLoad   = 3'd2,
      ClsStore  = 3'd3,
      ClsBranch = 3'd4,
      ClsNone   = 3'd7
   } op_class_e;

   localparam logic [6:0] OpcR      = 7'b0110011;
   localparam logic [6:0] OpcIAlu   = 7'b0010011;
   localparam logic [6:0] OpcLoad   = 7'b0000011;
   localparam logic [6:0] OpcStore  = 7'b0100011;
   localparam logic [6:0] OpcBranch = 7'b1100011;

   localparam logic [1:0] AluAdd   = 2'b00;
   localparam logic [1:0] AluSub   = 2'b01;
   localparam logic [1:0] AluFunct = 2'b10;

endpackage

// File: rtl/opcode_class_decode.sv
// Combinational opcode classifier: maps the 7-bit major opcode to a class and a legal flag.
module opcode_class_decode
   import ctrl_pkg::*;
(
   input  logic [6:0] opcode,
   output op_class_e  op_class,
   output logic       legal
);

   // Anything outside the five supported major opcodes is reported as illegal.
   always_comb begin
      op_class = ClsNone;
      legal    = 1'b1;
      case (opcode)
         OpcR:      op_class = ClsR;
         OpcIAlu:   op_class = ClsIAlu;
         OpcLoad:   op_class = ClsLoad;
         OpcStore:  op_class = ClsStore;
         OpcBranch: op_class = ClsBranch;
         default:   legal    = 1'b0;
      endcase
   end

endmodule

// File: rtl/multicycle_control_fsm.sv
// Multicycle processor control FSM with memory handshake timeout and retired-instruction counter.
module multicycle_control_fsm
   import ctrl_pkg::*;
#(
   parameter int unsigned MEM_TIMEOUT = 16
) (
   input  logic        clk,
   input  logic        rst,
   input  logic        start,
   input  logic        halt_req,
   input  logic [6:0]  opcode,
   input  logic        zero,
   input  logic        instr_ready,
   input  logic        mem_ready,
   output logic        instr_req,
   output logic        ir_write,
   output logic        pc_write,
   output logic        pc_src,
   output logic        reg_write,
   output logic        alu_src,
   output logic        mem_to_reg,
   output logic        mem_read,
   output logic        mem_write,
   output logic [1:0]  alu_op,
   output logic [2:0]  state,
   output logic        busy,
   output logic        retire,
   output logic        illegal,
   output logic        timeout,
   output logic [31:0] instr_count
);

   // The counter only ever holds 0..MEM_TIMEOUT-1; the final wait cycle is detected by compare.
   localparam int unsigned WaitW = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
   localparam logic [WaitW-1:0] WaitLast = WaitW'(MEM_TIMEOUT - 1);

   state_e           state_q, state_d;
   op_class_e        class_q, class_d;
   logic             illegal_q, illegal_d;
   logic             timeout_q, timeout_d;
   logic [WaitW-1:0] wait_q, wait_d;
   logic [31:0]      count_q, count_d;

   op_class_e dec_class;
   logic      dec_legal;

   opcode_class_decode u_decode (
      .opcode   (opcode),
      .op_class (dec_class),
      .legal    (dec_legal)
   );

   // State, latched opcode class, sticky faults, wait counter and retire counter.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state_q   <= StIdle;
         class_q   <= ClsNone;
         illegal_q <= 1'b0;
         timeout_q <= 1'b0;
         wait_q    <= '0;
         count_q   <= '0;
      end else begin
         state_q   <= state_d;
         class_q   <= class_d;
         illegal_q <= illegal_d;
         timeout_q <= timeout_d;
         wait_q    <= wait_d;
         count_q   <= count_d;
      end
   end

   // Next-state and datapath controls; wait counter is zero outside FETCH/MEM so it clears on entry.
   always_comb begin
      state_d    = state_q;
      class_d    = class_q;
      illegal_d  = illegal_q;
      timeout_d  = timeout_q;
      wait_d     = '0;
      instr_req  = 1'b0;
      ir_write   = 1'b0;
      pc_write   = 1'b0;
      pc_src     = 1'b0;
      reg_write  = 1'b0;
      alu_src    = 1'b0;
      mem_to_reg = 1'b0;
      mem_read   = 1'b0;
      mem_write  = 1'b0;
      alu_op     = AluAdd;
      retire     = 1'b0;
      case (state_q)
         StIdle: begin
            if (start) state_d = StFetch;
         end
         StFetch: begin
            instr_req = 1'b1;
            if (instr_ready) begin
               ir_write = 1'b1;
               state_d  = StDecode;
            end else if (wait_q == WaitLast) begin
               timeout_d = 1'b1;
               state_d   = StHalt;
            end else begin
               wait_d = wait_q + WaitW'(1);
            end
         end
         StDecode: begin
            if (dec_legal) begin
               class_d = dec_class;
               state_d = StExec;
            end else begin
               illegal_d = 1'b1;
               state_d   = StHalt;
            end
         end
         StExec: begin
            case (class_q)
               ClsR: begin
                  alu_op  = AluFunct;
                  state_d = StWb;
               end
               ClsIAlu: begin
                  alu_src = 1'b1;
                  alu_op  = AluFunct;
                  state_d = StWb;
               end
               ClsLoad, ClsStore: begin
                  alu_src = 1'b1;
                  state_d = StMem;
               end
               ClsBranch: begin
                  alu_op   = AluSub;
                  pc_write = 1'b1;
                  pc_src   = zero;
                  retire   = 1'b1;
                  state_d  = halt_req ? StIdle : StFetch;
               end
               default: state_d = StHalt;
            endcase
         end
         StMem: begin
            alu_src   = 1'b1;
            mem_read  = (class_q == ClsLoad);
            mem_write = (class_q != ClsLoad);
            // Ready in the last allowed cycle still completes normally.
            if (mem_ready) begin
               if (class_q == ClsLoad) begin
                  state_d = StWb;
               end else begin
                  pc_write = 1'b1;
                  retire   = 1'b1;
                  state_d  = halt_req ? StIdle : StFetch;
               end
            end else if (wait_q == WaitLast) begin
               timeout_d = 1'b1;
               state_d   = StHalt;
            end else begin
               wait_d = wait_q + WaitW'(1);
            end
         end
         StWb: begin
            reg_write  = 1'b1;
            mem_to_reg = (class_q == ClsLoad);
            pc_write   = 1'b1;
            retire     = 1'b1;
            state_d    = halt_req ? StIdle : StFetch;
         end
         StHalt: begin
            state_d = StHalt;
         end
         default: state_d = StIdle;
      endcase
      count_d = retire ? count_q + 32'd1 : count_q;
   end

   assign state       = state_q;
   assign busy        = (state_q != StIdle) && (state_q != StHalt);
   assign illegal     = illegal_q;
   assign timeout     = timeout_q;
   assign instr_count = count_q;

endmodule
